// File: rtl/spi_scan_receiver_pkg.sv
// Shared definitions for the SPI scan receiver: state encoding and default widths.
package spi_scan_receiver_pkg;

    localparam int SPI_RX_DW    = 8;
    localparam int SPI_RX_DEPTH = 16;
    localparam int SPI_RX_PTR_W = $clog2(SPI_RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MSTR = 2'b01
    } rx_state_t;

    // Bit counter must hold 0..dw+1 (saturating one past a full word).
    function automatic int bit_cnt_width(input int dw);
        return $clog2(dw + 2);
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Rise detectors for SCLK1/SCLK2/LAT. Pulses are registered so the FSM sees
// a clean one-cycle strobe; serial data is delayed by the same amount so the
// bit value stays aligned with its SCLK1 pulse.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk1,
    input  logic sclk2,
    input  logic lat,
    input  logic so,
    output logic sclk1_rise,
    output logic sclk2_rise,
    output logic lat_rise,
    output logic so_q
);

    logic sclk1_q;
    logic sclk2_q;
    logic lat_q;

    // Previous-level registers and registered rise pulses; held-high inputs at
    // reset release count as a rise because the history resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk1_q    <= 1'b0;
            sclk2_q    <= 1'b0;
            lat_q      <= 1'b0;
            sclk1_rise <= 1'b0;
            sclk2_rise <= 1'b0;
            lat_rise   <= 1'b0;
            so_q       <= 1'b0;
        end else begin
            sclk1_q    <= sclk1;
            sclk2_q    <= sclk2;
            lat_q      <= lat;
            sclk1_rise <= sclk1 & ~sclk1_q;
            sclk2_rise <= sclk2 & ~sclk2_q;
            lat_rise   <= lat & ~lat_q;
            so_q       <= so;
        end
    end

endmodule

// File: rtl/spi_scan_receiver.sv
// SPI scan-chain endpoint: deserialises LSB-first words clocked by the
// SCLK1/SCLK2 two-phase pair and latches each word into a register bank on LAT.
//
// state  | meaning
// S_IDLE | waiting for SCLK1 to present the next bit
// S_MSTR | bit captured in pend, waiting for SCLK2 to shift it in
module spi_scan_receiver
    import spi_scan_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_RX_DW,
    parameter int DEPTH      = SPI_RX_DEPTH,
    parameter int PTR_WIDTH  = SPI_RX_PTR_W
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  CLR,
    input  logic                  SCLK1,
    input  logic                  SCLK2,
    input  logic                  LAT,
    input  logic                  SPI_SO,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VLD,
    input  logic [PTR_WIDTH-1:0]  RD_ADDR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [PTR_WIDTH:0]    WORD_CNT,
    output logic                  OVF,
    output logic                  FRM_ERR,
    output logic                  PHS_ERR
);

    localparam int                   BCW      = bit_cnt_width(DATA_WIDTH);
    localparam logic [BCW-1:0]       BC_FULL  = BCW'(DATA_WIDTH);
    localparam logic [BCW-1:0]       BC_SAT   = BCW'(DATA_WIDTH + 1);
    localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH + 1)'(DEPTH);

    logic                  sclk1_rise;
    logic                  sclk2_rise;
    logic                  lat_rise;
    logic                  so_q;

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  pend;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] bank [DEPTH];

    logic                  take_pend;
    logic                  do_shift;
    logic                  phs_set;
    logic                  frm_set;
    logic                  lat_store;
    logic                  lat_ovf;
    logic                  bank_full;

    spi_edge_det u_edge_det (
        .clk        (CLK),
        .rst_n      (rst_n),
        .sclk1      (SCLK1),
        .sclk2      (SCLK2),
        .lat        (LAT),
        .so         (SPI_SO),
        .sclk1_rise (sclk1_rise),
        .sclk2_rise (sclk2_rise),
        .lat_rise   (lat_rise),
        .so_q       (so_q)
    );

    assign bank_full = (WORD_CNT == FULL_CNT);

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle actions; CLR beats LAT, LAT beats shift clocks.
    always_comb begin
        state_nxt = state;
        take_pend = 1'b0;
        do_shift  = 1'b0;
        phs_set   = 1'b0;
        frm_set   = 1'b0;
        lat_store = 1'b0;
        lat_ovf   = 1'b0;
        if (CLR) begin
            state_nxt = S_IDLE;
        end else if (lat_rise) begin
            state_nxt = S_IDLE;
            if (bit_cnt == BC_FULL) begin
                lat_store = ~bank_full;
                lat_ovf   = bank_full;
            end else begin
                frm_set = 1'b1;
            end
        end else if (sclk1_rise && sclk2_rise) begin
            phs_set = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sclk1_rise) begin
                        take_pend = 1'b1;
                        state_nxt = S_MSTR;
                    end
                end
                S_MSTR: begin
                    if (sclk2_rise) begin
                        do_shift  = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (sclk1_rise) begin
                        take_pend = 1'b1;
                        phs_set   = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Shift register, counters, output word and sticky flags.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            pend     <= 1'b0;
            bit_cnt  <= '0;
            DOUT     <= '0;
            DOUT_VLD <= 1'b0;
            WORD_CNT <= '0;
            OVF      <= 1'b0;
            FRM_ERR  <= 1'b0;
            PHS_ERR  <= 1'b0;
        end else begin
            DOUT_VLD <= 1'b0;
            if (CLR) begin
                bit_cnt  <= '0;
                WORD_CNT <= '0;
                OVF      <= 1'b0;
                FRM_ERR  <= 1'b0;
                PHS_ERR  <= 1'b0;
            end else begin
                if (take_pend) begin
                    pend <= so_q;
                end
                if (do_shift) begin
                    sreg <= {pend, sreg[DATA_WIDTH-1:1]};
                    if (bit_cnt != BC_SAT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (lat_rise) begin
                    bit_cnt <= '0;
                end
                if (lat_store || lat_ovf) begin
                    DOUT     <= sreg;
                    DOUT_VLD <= 1'b1;
                end
                if (lat_store) begin
                    WORD_CNT <= WORD_CNT + 1'b1;
                end
                if (lat_ovf) begin
                    OVF <= 1'b1;
                end
                if (frm_set) begin
                    FRM_ERR <= 1'b1;
                end
                if (phs_set) begin
                    PHS_ERR <= 1'b1;
                end
            end
        end
    end

    // Register bank; write pointer is the word count, so no wrap-around.
    always_ff @(posedge CLK) begin
        if (lat_store) begin
            bank[WORD_CNT[PTR_WIDTH-1:0]] <= sreg;
        end
    end

    assign RD_DATA = bank[RD_ADDR];

endmodule

// File: tb/tb_spi_scan_receiver.sv
// Directed bench for spi_scan_receiver: single word, stream, overflow,
// framing error, phase errors with CLR, and reset mid-word.
module tb_spi_scan_receiver;

    logic       CLK;
    logic       rst_n;
    logic       CLR;
    logic       SCLK1;
    logic       SCLK2;
    logic       LAT;
    logic       SPI_SO;
    logic [7:0] DOUT;
    logic       DOUT_VLD;
    logic [3:0] RD_ADDR;
    logic [7:0] RD_DATA;
    logic [4:0] WORD_CNT;
    logic       OVF;
    logic       FRM_ERR;
    logic       PHS_ERR;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] stream_bytes [14] = '{8'h04, 8'h43, 8'h00, 8'h41, 8'h03, 8'h08, 8'h01,
                                      8'h7B, 8'h12, 8'hA8, 8'h02, 8'h99, 8'h00, 8'hD8};

    spi_scan_receiver dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .CLR      (CLR),
        .SCLK1    (SCLK1),
        .SCLK2    (SCLK2),
        .LAT      (LAT),
        .SPI_SO   (SPI_SO),
        .DOUT     (DOUT),
        .DOUT_VLD (DOUT_VLD),
        .RD_ADDR  (RD_ADDR),
        .RD_DATA  (RD_DATA),
        .WORD_CNT (WORD_CNT),
        .OVF      (OVF),
        .FRM_ERR  (FRM_ERR),
        .PHS_ERR  (PHS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic send_bit(input logic b);
        @(negedge CLK); SPI_SO = b; SCLK1 = 1'b1;
        @(negedge CLK); SCLK1 = 1'b0; SCLK2 = 1'b1;
        @(negedge CLK); SCLK2 = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    // Returns DOUT_VLD two cycles after the LAT rise, where the update lands.
    task automatic latch(output logic vld);
        @(negedge CLK); LAT = 1'b1;
        @(negedge CLK); LAT = 1'b0;
        @(negedge CLK); vld = DOUT_VLD;
    endtask

    task automatic pulse_clr();
        @(negedge CLK); CLR = 1'b1;
        @(negedge CLK); CLR = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        n_vec++; if (DOUT !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
        n_vec++; if (DOUT_VLD !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", DOUT_VLD); end
        n_vec++; if (WORD_CNT !== 5'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", WORD_CNT); end
        n_vec++; if ({OVF, FRM_ERR, PHS_ERR} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {OVF, FRM_ERR, PHS_ERR}); end
    endtask

    task automatic test_single_word();
        logic v;
        send_word(8'hAB);
        latch(v);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL single_vld got=%b exp=1", v); end
        n_vec++; if (DOUT !== 8'hAB) begin n_err++; $display("FAIL single_dout got=%h exp=ab", DOUT); end
        n_vec++; if (WORD_CNT !== 5'd1) begin n_err++; $display("FAIL single_cnt got=%0d exp=1", WORD_CNT); end
        RD_ADDR = 4'd0; #1;
        n_vec++; if (RD_DATA !== 8'hAB) begin n_err++; $display("FAIL single_bank0 got=%h exp=ab", RD_DATA); end
        @(negedge CLK);
        n_vec++; if (DOUT_VLD !== 1'b0) begin n_err++; $display("FAIL single_vld_pulse got=%b exp=0", DOUT_VLD); end
    endtask

    task automatic test_stream();
        logic v;
        pulse_clr();
        n_vec++; if (WORD_CNT !== 5'd0) begin n_err++; $display("FAIL stream_clr_cnt got=%0d exp=0", WORD_CNT); end
        for (int i = 0; i < 14; i++) begin
            send_word(stream_bytes[i]);
            latch(v);
            n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL stream_vld[%0d] got=%b exp=1", i, v); end
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK); RD_ADDR = 4'(i); #1;
            n_vec++; if (RD_DATA !== stream_bytes[i]) begin n_err++; $display("FAIL stream_bank[%0d] got=%h exp=%h", i, RD_DATA, stream_bytes[i]); end
        end
        n_vec++; if (WORD_CNT !== 5'd14) begin n_err++; $display("FAIL stream_cnt got=%0d exp=14", WORD_CNT); end
        n_vec++; if ({OVF, FRM_ERR, PHS_ERR} !== 3'b000) begin n_err++; $display("FAIL stream_flags got=%b exp=000", {OVF, FRM_ERR, PHS_ERR}); end
    endtask

    task automatic test_overflow();
        logic v;
        pulse_clr();
        for (int i = 1; i <= 16; i++) begin
            send_word(8'hC0 + 8'(i));
            latch(v);
        end
        n_vec++; if (WORD_CNT !== 5'd16) begin n_err++; $display("FAIL ovf_cnt16 got=%0d exp=16", WORD_CNT); end
        n_vec++; if (OVF !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", OVF); end
        send_word(8'hD1);
        latch(v);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL ovf_vld got=%b exp=1", v); end
        n_vec++; if (OVF !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", OVF); end
        n_vec++; if (WORD_CNT !== 5'd16) begin n_err++; $display("FAIL ovf_cnt got=%0d exp=16", WORD_CNT); end
        n_vec++; if (DOUT !== 8'hD1) begin n_err++; $display("FAIL ovf_dout got=%h exp=d1", DOUT); end
        RD_ADDR = 4'd15; #1;
        n_vec++; if (RD_DATA !== 8'hD0) begin n_err++; $display("FAIL ovf_bank15 got=%h exp=d0", RD_DATA); end
        RD_ADDR = 4'd0; #1;
        n_vec++; if (RD_DATA !== 8'hC1) begin n_err++; $display("FAIL ovf_bank0 got=%h exp=c1", RD_DATA); end
    endtask

    task automatic test_frame_error();
        logic v;
        pulse_clr();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        latch(v);
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL frm_vld got=%b exp=0", v); end
        n_vec++; if (FRM_ERR !== 1'b1) begin n_err++; $display("FAIL frm_flag got=%b exp=1", FRM_ERR); end
        n_vec++; if (WORD_CNT !== 5'd0) begin n_err++; $display("FAIL frm_cnt got=%0d exp=0", WORD_CNT); end
        send_word(8'h3C);
        latch(v);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL frm_next_vld got=%b exp=1", v); end
        n_vec++; if (DOUT !== 8'h3C) begin n_err++; $display("FAIL frm_next_dout got=%h exp=3c", DOUT); end
        n_vec++; if (WORD_CNT !== 5'd1) begin n_err++; $display("FAIL frm_next_cnt got=%0d exp=1", WORD_CNT); end
        RD_ADDR = 4'd0; #1;
        n_vec++; if (RD_DATA !== 8'h3C) begin n_err++; $display("FAIL frm_next_bank0 got=%h exp=3c", RD_DATA); end
    endtask

    task automatic test_phase_error();
        pulse_clr();
        // SCLK2 alone while idle is harmless.
        @(negedge CLK); SCLK2 = 1'b1;
        @(negedge CLK); SCLK2 = 1'b0;
        @(negedge CLK); @(negedge CLK);
        n_vec++; if (PHS_ERR !== 1'b0) begin n_err++; $display("FAIL phs_sclk2_idle got=%b exp=0", PHS_ERR); end
        // Both phases rising together.
        @(negedge CLK); SCLK1 = 1'b1; SCLK2 = 1'b1;
        @(negedge CLK); SCLK1 = 1'b0; SCLK2 = 1'b0;
        @(negedge CLK); @(negedge CLK);
        n_vec++; if (PHS_ERR !== 1'b1) begin n_err++; $display("FAIL phs_same_cycle got=%b exp=1", PHS_ERR); end
        pulse_clr();
        n_vec++; if ({OVF, FRM_ERR, PHS_ERR} !== 3'b000) begin n_err++; $display("FAIL phs_clr_flags got=%b exp=000", {OVF, FRM_ERR, PHS_ERR}); end
        n_vec++; if (WORD_CNT !== 5'd0) begin n_err++; $display("FAIL phs_clr_cnt got=%0d exp=0", WORD_CNT); end
        // Double SCLK1 without an SCLK2 in between.
        @(negedge CLK); SCLK1 = 1'b1;
        @(negedge CLK); SCLK1 = 1'b0;
        @(negedge CLK); SCLK1 = 1'b1;
        @(negedge CLK); SCLK1 = 1'b0;
        @(negedge CLK); @(negedge CLK);
        n_vec++; if (PHS_ERR !== 1'b1) begin n_err++; $display("FAIL phs_double_sclk1 got=%b exp=1", PHS_ERR); end
        pulse_clr();
        n_vec++; if ({OVF, FRM_ERR, PHS_ERR} !== 3'b000) begin n_err++; $display("FAIL phs_clr2_flags got=%b exp=000", {OVF, FRM_ERR, PHS_ERR}); end
    endtask

    task automatic test_reset_mid_word();
        logic v;
        // Leave a known non-zero DOUT in place before the reset.
        send_word(8'h96);
        latch(v);
        n_vec++; if (DOUT !== 8'h96) begin n_err++; $display("FAIL rst_pre_dout got=%h exp=96", DOUT); end
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge CLK); rst_n = 1'b0; #1;
        n_vec++; if (DOUT !== 8'h00) begin n_err++; $display("FAIL rst_mid_dout got=%h exp=00", DOUT); end
        n_vec++; if (WORD_CNT !== 5'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d exp=0", WORD_CNT); end
        @(negedge CLK); @(negedge CLK); rst_n = 1'b1;
        send_word(8'h5A);
        latch(v);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL rst_after_vld got=%b exp=1", v); end
        n_vec++; if (DOUT !== 8'h5A) begin n_err++; $display("FAIL rst_after_dout got=%h exp=5a", DOUT); end
        n_vec++; if (WORD_CNT !== 5'd1) begin n_err++; $display("FAIL rst_after_cnt got=%0d exp=1", WORD_CNT); end
        n_vec++; if (FRM_ERR !== 1'b0) begin n_err++; $display("FAIL rst_after_frm got=%b exp=0", FRM_ERR); end
    endtask

    initial begin
        rst_n   = 1'b0;
        CLR     = 1'b0;
        SCLK1   = 1'b0;
        SCLK2   = 1'b0;
        LAT     = 1'b0;
        SPI_SO  = 1'b0;
        RD_ADDR = 4'd0;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        test_reset();
        test_single_word();
        test_stream();
        test_overflow();
        test_frame_error();
        test_phase_error();
        test_reset_mid_word();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
